// File: rtl/shift_unit_arbiter.sv
// ---------------------------------------------------------------------------
// shift_unit_arbiter
//   Two requesters share one WIDTH-bit shifter (SLL / SRL / SRA). One op is
//   in flight at a time: IDLE grants and captures, EXEC computes and
//   registers the result, RESP holds it until the consumer takes it.
//
//   Optional feature macro: SHIFT_ARB_STATS_EN
//     When defined, adds grant_cnt0 / grant_cnt1, per-requester grant
//     counters that wrap and clear on reset.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   reqN_valid/ready       request handshake per requester (ready is comb,
//                          only ever high in IDLE)
//   reqN_op/a/b            op (00 SLL, 01 SRL, 10 SRA, 11 illegal),
//                          value, unsigned shift amount
//   rsp_valid/ready        response handshake
//   rsp_id/data/ovf        owner, result, overflow/illegal flag (registered,
//                          held while rsp_valid && !rsp_ready)
//   busy                   FSM not in IDLE
//   grant_cnt0/1           (SHIFT_ARB_STATS_EN only) grants per requester
// ---------------------------------------------------------------------------
module shift_unit_arbiter #(
    parameter int WIDTH         = 16,
    parameter int PRIORITY_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_ovf,
    output logic             busy
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
`endif
);

    localparam int SH_W = $clog2(WIDTH);
    localparam bit RR   = (PRIORITY_MODE == 0);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    req_t   cap;
    logic   cap_id;

    // Returns {ovf, data}. The amount is the full unsigned B operand, so
    // anything >= WIDTH saturates rather than wrapping on the low bits.
    function automatic logic [WIDTH:0] do_shift(input req_t r);
        logic                 big;
        logic [SH_W-1:0]      sh;
        logic [2*WIDTH-1:0]   wide;
        logic [WIDTH-1:0]     data;
        logic                 ovf;
        big  = (r.b >= WIDTH'(WIDTH));
        sh   = r.b[SH_W-1:0];
        wide = {{WIDTH{1'b0}}, r.a} << sh;
        data = '0;
        ovf  = 1'b0;
        case (r.op)
            OP_SLL: begin
                // Bits pushed past the top land in the upper half of wide.
                data = big ? '0 : wide[WIDTH-1:0];
                ovf  = big ? (|r.a) : (|wide[2*WIDTH-1:WIDTH]);
            end
            OP_SRL: data = big ? '0 : (r.a >> sh);
            OP_SRA: data = big ? {WIDTH{r.a[WIDTH-1]}}
                               : WIDTH'($signed(r.a) >>> sh);
            default: begin
                data = '0;
                ovf  = 1'b1;
            end
        endcase
        return {ovf, data};
    endfunction

    // Arbitration: single requester always wins; on a tie round-robin
    // picks !last_grant, fixed priority always picks req0.
    logic any_vld, gnt1, idle;
    assign any_vld = req0_valid | req1_valid;
    assign gnt1    = req1_valid & (~req0_valid | (RR & ~last_grant));
    assign idle    = (state == S_IDLE) & ~rst;

    assign req0_ready = idle & any_vld & ~gnt1;
    assign req1_ready = idle & gnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            cap        <= '0;
            cap_id     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_ovf    <= 1'b0;
            busy       <= 1'b0;
`ifdef SHIFT_ARB_STATS_EN
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_vld) begin
                        cap    <= gnt1 ? req_t'{req1_op, req1_a, req1_b}
                                       : req_t'{req0_op, req0_a, req0_b};
                        cap_id <= gnt1;
                        if (RR) last_grant <= gnt1;
                        busy   <= 1'b1;
                        state  <= S_EXEC;
`ifdef SHIFT_ARB_STATS_EN
                        if (gnt1) grant_cnt1 <= grant_cnt1 + 16'd1;
                        else      grant_cnt0 <= grant_cnt0 + 16'd1;
`endif
                    end
                end
                S_EXEC: begin
                    {rsp_ovf, rsp_data} <= do_shift(cap);
                    rsp_id    <= cap_id;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    // Return to IDLE only; a new grant waits a cycle.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
